axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: arbitrates two AXI read masters onto one slave, one transaction outstanding.
// Ports: ACLK clock; ARSETn synchronous active-low reset; m0_*/m1_* master AR and R channels;
// s_* shared slave AR and R channels; gnt one-hot granted master (0 when none); busy high outside IDLE.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = `D_ID_WIDTH,
  parameter int ADDR_WIDTH = `D_ADDR_WIDTH,
  parameter int DATA_WIDTH = `D_DATA_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARSETn,
  input  logic [ID_WIDTH-1:0]   m0_ARID,
  input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
  input  logic [7:0]            m0_ARLEN,
  input  logic [2:0]            m0_ARSIZE,
  input  logic [1:0]            m0_ARBURST,
  input  logic [2:0]            m0_ARPROT,
  input  logic                  m0_ARVALID,
  output logic                  m0_ARREADY,
  output logic [ID_WIDTH-1:0]   m0_RID,
  output logic [DATA_WIDTH-1:0] m0_RDATA,
  output logic [1:0]            m0_RRESP,
  output logic                  m0_RLAST,
  output logic                  m0_RVALID,
  input  logic                  m0_RREADY,
  input  logic [ID_WIDTH-1:0]   m1_ARID,
  input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
  input  logic [7:0]            m1_ARLEN,
  input  logic [2:0]            m1_ARSIZE,
  input  logic [1:0]            m1_ARBURST,
  input  logic [2:0]            m1_ARPROT,
  input  logic                  m1_ARVALID,
  output logic                  m1_ARREADY,
  output logic [ID_WIDTH-1:0]   m1_RID,
  output logic [DATA_WIDTH-1:0] m1_RDATA,
  output logic [1:0]            m1_RRESP,
  output logic                  m1_RLAST,
  output logic                  m1_RVALID,
  input  logic                  m1_RREADY,
  output logic [ID_WIDTH-1:0]   s_ARID,
  output logic [ADDR_WIDTH-1:0] s_ARADDR,
  output logic [7:0]            s_ARLEN,
  output logic [2:0]            s_ARSIZE,
  output logic [1:0]            s_ARBURST,
  output logic [2:0]            s_ARPROT,
  output logic                  s_ARVALID,
  input  logic                  s_ARREADY,
  input  logic [ID_WIDTH-1:0]   s_RID,
  input  logic [DATA_WIDTH-1:0] s_RDATA,
  input  logic [1:0]            s_RRESP,
  input  logic                  s_RLAST,
  input  logic                  s_RVALID,
  output logic                  s_RREADY,
  output logic [1:0]            gnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [1:0] gnt_n;
  logic pick1, sel1, done;
  assign sel1 = gnt[1];
  assign done = state == DATA && s_RVALID && s_RREADY && s_RLAST;
`ifdef AXI_RD_ARB_RR_EN
  // ptr names the master that wins a tie; after each completion it points away from the master just served.
  logic ptr;
  assign pick1 = m0_ARVALID && m1_ARVALID ? ptr : !m0_ARVALID;
  always_ff @(posedge ACLK)
    if (!ARSETn) ptr <= 1'b0;
    else if (done) ptr <= gnt[0];
`else
  assign pick1 = !m0_ARVALID;
`endif
  always_ff @(posedge ACLK) begin
    if (!ARSETn) begin
      state <= IDLE;
      gnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    case (state)
      IDLE: if (m0_ARVALID || m1_ARVALID) begin
        state_n = ADDR;
        gnt_n = pick1 ? 2'b10 : 2'b01;
      end
      ADDR: if (s_ARREADY) state_n = DATA;
      DATA: if (done) begin
        state_n = IDLE;
        gnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n = '0;
      end
    endcase
  end
  assign busy = state != IDLE;
  assign s_ARVALID = state == ADDR;
  assign s_ARID = sel1 ? m1_ARID : m0_ARID;
  assign s_ARADDR = sel1 ? m1_ARADDR : m0_ARADDR;
  assign s_ARLEN = sel1 ? m1_ARLEN : m0_ARLEN;
  assign s_ARSIZE = sel1 ? m1_ARSIZE : m0_ARSIZE;
  assign s_ARBURST = sel1 ? m1_ARBURST : m0_ARBURST;
  assign s_ARPROT = sel1 ? m1_ARPROT : m0_ARPROT;
  assign m0_ARREADY = s_ARVALID && gnt[0] && s_ARREADY;
  assign m1_ARREADY = s_ARVALID && gnt[1] && s_ARREADY;
  // R payload fans out to both masters; only the granted master's RVALID qualifies it.
  assign s_RREADY = state == DATA && (sel1 ? m1_RREADY : m0_RREADY);
  assign m0_RVALID = state == DATA && gnt[0] && s_RVALID;
  assign m1_RVALID = state == DATA && gnt[1] && s_RVALID;
  assign m0_RID = s_RID;
  assign m0_RDATA = s_RDATA;
  assign m0_RRESP = s_RRESP;
  assign m0_RLAST = s_RLAST;
  assign m1_RID = s_RID;
  assign m1_RDATA = s_RDATA;
  assign m1_RRESP = s_RRESP;
  assign m1_RLAST = s_RLAST;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter with reactive master and slave models.
module tb_axi_rd_arbiter;
  localparam int IW = 4, AW = 32, DW = 32;
  logic ACLK = 1'b0, ARSETn = 1'b0;
  logic [IW-1:0] m0_ARID, m1_ARID, s_ARID, m0_RID, m1_RID, s_RID;
  logic [AW-1:0] m0_ARADDR, m1_ARADDR, s_ARADDR;
  logic [7:0] m0_ARLEN, m1_ARLEN, s_ARLEN;
  logic [2:0] m0_ARSIZE, m1_ARSIZE, s_ARSIZE, m0_ARPROT, m1_ARPROT, s_ARPROT;
  logic [1:0] m0_ARBURST, m1_ARBURST, s_ARBURST;
  logic m0_ARVALID, m1_ARVALID, s_ARVALID, m0_ARREADY, m1_ARREADY, s_ARREADY;
  logic [DW-1:0] m0_RDATA, m1_RDATA, s_RDATA;
  logic [1:0] m0_RRESP, m1_RRESP, s_RRESP, gnt;
  logic m0_RLAST, m1_RLAST, s_RLAST, m0_RVALID, m1_RVALID, s_RVALID;
  logic m0_RREADY, m1_RREADY, s_RREADY, busy;
  typedef struct {logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len;} req_t;
  req_t mq0[$], mq1[$];
  logic [63:0] sb[$];
  int total = 0, passed = 0, ar_hold = 0;
  bit spur = 0, tog = 0;
  always #5 ACLK = ~ACLK;
  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARSETn(ARSETn),
    .m0_ARID(m0_ARID), .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE),
    .m0_ARBURST(m0_ARBURST), .m0_ARPROT(m0_ARPROT), .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
    .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .m1_ARID(m1_ARID), .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE),
    .m1_ARBURST(m1_ARBURST), .m1_ARPROT(m1_ARPROT), .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
    .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_ARPROT(s_ARPROT), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .gnt(gnt), .busy(busy)
  );
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endfunction
  function automatic void sb_check(string nm, logic [63:0] act);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: got %h with nothing expected", nm, act);
    end else chk(nm, act, sb.pop_front());
  endfunction
  // Fixed AR side-band attributes per master: {ARSIZE, ARBURST, ARPROT}.
  function automatic logic [7:0] misc(int m);
    return m == 1 ? {3'd3, 2'd2, 3'd2} : {3'd2, 2'd1, 3'd0};
  endfunction
  // Slave returns data = ARADDR + beat index and RRESP = ARID[1:0].
  function automatic void expect_rd(int m, logic [IW-1:0] id, logic [AW-1:0] addr, logic [7:0] len, int nb);
    sb.push_back({1'b0, 63'({2'(m), id, addr, len, misc(m)})});
    for (int k = 0; k < nb; k++)
      sb.push_back({1'b1, 63'({2'(m), id, addr + 32'(k), k == int'(len), id[1:0]})});
  endfunction
  task automatic wait_done(string nm);
    int n = 0;
    while ((sb.size() != 0 || busy || mq0.size() != 0 || mq1.size() != 0) && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    chk({nm, "_drain"}, {busy, 32'(sb.size())}, 64'd0);
  endtask
  initial begin : masters
    bit hs0, hs1;
    {m0_ARVALID, m1_ARVALID, m0_ARID, m1_ARID, m0_ARADDR, m1_ARADDR, m0_ARLEN, m1_ARLEN} = '0;
    {m0_ARSIZE, m0_ARBURST, m0_ARPROT} = misc(0);
    {m1_ARSIZE, m1_ARBURST, m1_ARPROT} = misc(1);
    m0_RREADY = 1'b1;
    m1_RREADY = 1'b1;
    forever begin
      @(negedge ACLK);
      hs0 = m0_ARVALID && m0_ARREADY && ARSETn;
      hs1 = m1_ARVALID && m1_ARREADY && ARSETn;
      @(posedge ACLK);
      #1;
      if (hs0) mq0.delete(0);
      if (hs1) mq1.delete(0);
      m0_ARVALID = mq0.size() != 0;
      m1_ARVALID = mq1.size() != 0;
      if (m0_ARVALID) {m0_ARID, m0_ARADDR, m0_ARLEN} = {mq0[0].id, mq0[0].addr, mq0[0].len};
      if (m1_ARVALID) {m1_ARID, m1_ARADDR, m1_ARLEN} = {mq1[0].id, mq1[0].addr, mq1[0].len};
      m0_RREADY = tog ? !m0_RREADY : 1'b1;
    end
  end
  initial begin : slave
    bit rst, ar_hs, r_hs, ar_wait, active;
    int stall_cnt, beat;
    logic [IW-1:0] cid;
    logic [AW-1:0] caddr;
    logic [7:0] clen;
    active = 0; stall_cnt = 0; beat = 0; cid = '0; caddr = '0; clen = '0;
    s_ARREADY = 1'b1; s_RVALID = 1'b0; s_RID = '0; s_RDATA = '0; s_RRESP = '0; s_RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      rst = !ARSETn;
      ar_hs = s_ARVALID && s_ARREADY;
      r_hs = s_RVALID && s_RREADY;
      ar_wait = s_ARVALID && !s_ARREADY;
      if (ar_hs) {cid, caddr, clen} = {s_ARID, s_ARADDR, s_ARLEN};
      @(posedge ACLK);
      #1;
      if (rst) begin
        active = 0;
        stall_cnt = 0;
      end else begin
        if (ar_hs) begin
          active = 1;
          beat = 0;
          stall_cnt = 0;
        end else if (ar_wait) stall_cnt++;
        if (r_hs && active) begin
          if (beat == int'(clen)) active = 0;
          else beat++;
        end
      end
      s_ARREADY = stall_cnt >= ar_hold;
      s_RVALID = active || spur;
      s_RID = cid;
      s_RDATA = caddr + DW'(beat);
      s_RRESP = cid[1:0];
      s_RLAST = active ? beat == int'(clen) : 1'b1;
    end
  end
  initial begin : monitor
    logic [1:0] gi;
    forever begin
      @(negedge ACLK);
      gi = gnt == 2'b01 ? 2'd0 : gnt == 2'b10 ? 2'd1 : 2'd3;
      if (ARSETn && s_ARVALID && s_ARREADY)
        sb_check("ar", {1'b0, 63'({gi, s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARPROT})});
      if (ARSETn && m0_RVALID && m0_RREADY)
        sb_check("r_m0", {1'b1, 63'({2'd0, m0_RID, m0_RDATA, m0_RLAST, m0_RRESP})});
      if (ARSETn && m1_RVALID && m1_RREADY)
        sb_check("r_m1", {1'b1, 63'({2'd1, m1_RID, m1_RDATA, m1_RLAST, m1_RRESP})});
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 20000 cycles");
    $fatal(1);
  end
  initial begin : stim
    @(negedge ACLK);
    mq0.push_back('{4'h1, 32'h100, 8'd3});
    expect_rd(0, 4'h1, 32'h100, 8'd3, 4);
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", {gnt, busy, s_ARVALID, s_RREADY, m0_ARREADY, m1_ARREADY, m0_RVALID, m1_RVALID}, 64'd0);
    @(posedge ACLK);
    #1 ARSETn = 1'b1;
    @(negedge ACLK);
    chk("ar_latency_idle", {s_ARVALID, gnt}, 64'd0);
    @(negedge ACLK);
    chk("ar_latency_addr", {s_ARVALID, gnt, busy}, {1'b1, 2'b01, 1'b1});
    wait_done("single_m0");
    @(negedge ACLK);
    ar_hold = 5;
    mq1.push_back('{4'h5, 32'h300, 8'd0});
    expect_rd(1, 4'h5, 32'h300, 8'd0, 1);
    for (int n = 0; n < 50 && !s_ARVALID; n++) @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {s_ARVALID, s_ARREADY, m0_ARREADY, m1_ARREADY, gnt, s_ARID, s_ARADDR, s_ARLEN},
          {4'b1000, 2'b10, 4'h5, 32'h300, 8'd0});
      @(negedge ACLK);
    end
    chk("stall_release", {s_ARVALID, s_ARREADY, m0_ARREADY, m1_ARREADY, s_ARADDR}, {4'b1101, 32'h300});
    ar_hold = 0;
    wait_done("stall");
    @(negedge ACLK);
    for (int k = 0; k < 3; k++) begin
      mq0.push_back('{4'h1, 32'h1000 + 32'(k * 16), 8'd1});
      mq1.push_back('{4'h2, 32'h2000 + 32'(k * 16), 8'd1});
    end
`ifdef AXI_RD_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      expect_rd(0, 4'h1, 32'h1000 + 32'(k * 16), 8'd1, 2);
      expect_rd(1, 4'h2, 32'h2000 + 32'(k * 16), 8'd1, 2);
    end
`else
    for (int k = 0; k < 3; k++) expect_rd(0, 4'h1, 32'h1000 + 32'(k * 16), 8'd1, 2);
    for (int k = 0; k < 3; k++) expect_rd(1, 4'h2, 32'h2000 + 32'(k * 16), 8'd1, 2);
`endif
    wait_done("arbitrate");
    @(negedge ACLK);
    tog = 1;
    mq0.push_back('{4'h6, 32'h200, 8'd3});
    expect_rd(0, 4'h6, 32'h200, 8'd3, 4);
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      @(negedge ACLK);
      if (m0_RVALID) chk("rready_mirror", s_RREADY, m0_RREADY);
    end
    tog = 0;
    wait_done("toggle");
    @(negedge ACLK);
    mq0.push_back('{4'h3, 32'h400, 8'd3});
    expect_rd(0, 4'h3, 32'h400, 8'd3, 1);
    for (int n = 0; n < 40 && !(m0_RVALID && m0_RREADY); n++) @(negedge ACLK);
    chk("beat1_seen", {m0_RVALID, m0_RREADY, m0_RDATA}, {2'b11, 32'h400});
    @(posedge ACLK);
    #1 ARSETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_reset", {gnt, busy, s_ARVALID, s_RREADY, m0_ARREADY, m1_ARREADY, m0_RVALID, m1_RVALID}, 64'd0);
    @(posedge ACLK);
    #1 ARSETn = 1'b1;
    @(negedge ACLK);
    spur = 1;
    repeat (2) begin
      @(negedge ACLK);
      chk("spurious_r", {s_RVALID, s_RREADY, m0_RVALID, m1_RVALID, busy}, {5'b10000});
    end
    spur = 0;
    mq1.push_back('{4'h7, 32'h500, 8'd2});
    expect_rd(1, 4'h7, 32'h500, 8'd2, 3);
    wait_done("after_reset_m1");
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
